// File: rtl/nes_mem_pkg.sv
// Shared memory-map definitions for the NES-style memory subsystem:
// the sprite-DMA state encoding, the DMA trigger register address and
// the size of the sprite attribute memory.
package nes_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_REG = 16'h4014;
  localparam int          OAM_SIZE    = 256;

endpackage

// File: rtl/wr_edge_det.sv
// Rising-edge detector for the CPU write strobe.  The detector stays
// disarmed after reset until the strobe has been seen low once, so a
// strobe held high across reset cannot fire a trigger.
module wr_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic we,
  output logic rise
);

  logic prev_we;
  logic armed;

  // Remember last cycle's strobe and arm once the strobe has been low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_we <= 1'b0;
      armed   <= 1'b0;
    end else begin
      prev_we <= we;
      if (!we) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = we & ~prev_we & armed;

endmodule

// File: rtl/oam_dma_engine.sv
// Sprite (OAM) DMA engine.  A CPU write to DMA_REG halts the CPU and
// copies XFER_LEN bytes from page {cpu_wdata, 8'h00} into OAM starting
// at the current OAMADDR, one read/write pair per two cycles, with an
// optional alignment cycle so that every read lands on an even cycle.
module oam_dma_engine
  import nes_mem_pkg::*;
#(
  parameter logic [15:0] DMA_REG  = OAM_DMA_REG,
  parameter int          XFER_LEN = OAM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  oam_base,
  input  logic [7:0]  ram_rdata,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_done
);

  localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

  dma_state_t state_r;
  dma_state_t state_next;
  logic [8:0] idx_r;
  logic [8:0] idx_next;
  logic [7:0] page_r;
  logic [7:0] page_next;
  logic       cyc_odd_r;
  logic       we_rise;
  logic       trigger;

  wr_edge_det u_wr_edge_det (
    .clk   (clk),
    .reset (reset),
    .we    (cpu_we),
    .rise  (we_rise)
  );

  assign trigger = we_rise && (cpu_addr == DMA_REG);

  // Free-running cycle parity used to align reads onto even cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_odd_r <= 1'b0;
    end else begin
      cyc_odd_r <= ~cyc_odd_r;
    end
  end

  // State, byte index and source page registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= 9'd0;
      page_r  <= 8'd0;
    end else begin
      state_r <= state_next;
      idx_r   <= idx_next;
      page_r  <= page_next;
    end
  end

  // Next-state logic and per-state bus outputs; outputs idle at zero.
  always_comb begin
    state_next = state_r;
    idx_next   = idx_r;
    page_next  = page_r;
    dma_active = 1'b0;
    dma_addr   = 16'd0;
    dma_rd     = 1'b0;
    oam_addr   = 8'd0;
    oam_wdata  = 8'd0;
    oam_we     = 1'b0;
    dma_done   = 1'b0;

    case (state_r)
      IDLE: begin
        if (trigger) begin
          state_next = HALT;
          page_next  = cpu_wdata;
          idx_next   = 9'd0;
        end else begin
          state_next = IDLE;
        end
      end

      HALT: begin
        dma_active = 1'b1;
        // An odd HALT cycle means the next cycle is already even.
        if (cyc_odd_r) begin
          state_next = READ;
        end else begin
          state_next = ALIGN;
        end
      end

      ALIGN: begin
        dma_active = 1'b1;
        state_next = READ;
      end

      READ: begin
        dma_active = 1'b1;
        dma_rd     = 1'b1;
        dma_addr   = {page_r, idx_r[7:0]};
        state_next = WRITE;
      end

      WRITE: begin
        dma_active = 1'b1;
        oam_we     = 1'b1;
        oam_wdata  = ram_rdata;
        // OAMADDR is taken live each write; the sum wraps within OAM.
        oam_addr   = oam_base + idx_r[7:0];
        if (idx_r == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_r + 9'd1;
          state_next = READ;
        end
      end

      DONE: begin
        dma_done   = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Self-checking bench for oam_dma_engine: a directed scenario table,
// hand-written reset sequences and randomized transfers, all compared
// cycle by cycle against a timeline model of the transfer.
module tb_oam_dma_engine;

  localparam logic [15:0] REG_ADDR = 16'h4014;
  localparam int          NBYTES   = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = 16'd0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic [7:0]  oam_base = 8'd0;
  logic [7:0]  ram_rdata = 8'd0;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_done;

  oam_dma_engine #(.DMA_REG(16'h4014), .XFER_LEN(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .oam_base   (oam_base),
    .ram_rdata  (ram_rdata),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_rd     (dma_rd),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_we     (oam_we),
    .dma_done   (dma_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] mem [0:65535];
  logic        last_rd = 1'b0;
  logic [15:0] last_addr = 16'd0;

  // Transfer timeline model: one transfer starts with HALT at m_halt.
  bit         m_busy = 1'b0;
  int         m_halt = 0;
  int         m_align = 0;
  logic [7:0] m_page = 8'd0;
  bit         m_prev = 1'b0;
  bit         m_armed = 1'b0;

  // Observed statistics for the current scenario.
  int          act_cnt, we_cnt, done_cnt;
  bit          rd_seen, oa_seen;
  logic [15:0] rd_first, rd_last;
  logic [7:0]  oa_first, oa_last;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  page;
    logic [7:0]  base;
    bit          align;
    int          hold;
    bit          second;
    int          exp_act;
    int          exp_we;
    int          exp_done;
    logic [15:0] exp_rd_first;
    logic [15:0] exp_rd_last;
    logic [7:0]  exp_oa_first;
    logic [7:0]  exp_oa_last;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [35:0] outs_now();
    return {dma_active, dma_rd, dma_addr, oam_we, oam_addr, oam_wdata, dma_done};
  endfunction

  function automatic bit model_idle(int c);
    return !m_busy || (c > m_halt + 1 + m_align + 2 * NBYTES);
  endfunction

  // Expected outputs at cycle c from the position inside the transfer.
  function automatic logic [35:0] model_out(int c);
    logic act, rd, we, dn;
    logic [15:0] a;
    logic [7:0] oa, wd;
    int o, r, i;
    act = 1'b0; rd = 1'b0; we = 1'b0; dn = 1'b0;
    a = 16'd0; oa = 8'd0; wd = 8'd0;
    if (m_busy) begin
      o = c - m_halt;
      r = o - 1 - m_align;
      if (o >= 0) begin
        if (r < 0) begin
          act = 1'b1;
        end else if (r < 2 * NBYTES) begin
          act = 1'b1;
          i = r / 2;
          if (r % 2 == 0) begin
            rd = 1'b1;
            a  = {m_page, 8'(i)};
          end else begin
            we = 1'b1;
            oa = 8'(int'(oam_base) + i);
            wd = mem[{m_page, 8'(i)}];
          end
        end else if (r == 2 * NBYTES) begin
          dn = 1'b1;
        end
      end
    end
    return {act, rd, a, we, oa, wd, dn};
  endfunction

  task automatic check(string name, logic [35:0] got, logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_update(int c);
    if (cpu_we && !m_prev && m_armed && cpu_addr == REG_ADDR && model_idle(c)) begin
      m_busy  = 1'b1;
      m_halt  = c + 1;
      m_align = ((c + 1) % 2 == 0) ? 1 : 0;
      m_page  = cpu_wdata;
    end
    m_prev = cpu_we;
    if (!cpu_we) m_armed = 1'b1;
  endtask

  task automatic clear_stats();
    act_cnt = 0; we_cnt = 0; done_cnt = 0;
    rd_seen = 1'b0; oa_seen = 1'b0;
    rd_first = 16'd0; rd_last = 16'd0; oa_first = 8'd0; oa_last = 8'd0;
  endtask

  // One clock cycle: answer the previous read, compare, advance model.
  task automatic step();
    @(negedge clk);
    ram_rdata = last_rd ? mem[last_addr] : 8'($urandom);
    #1;
    check("outputs", outs_now(), model_out(cyc));
    if (dma_active) act_cnt++;
    if (dma_rd) begin
      if (!rd_seen) rd_first = dma_addr;
      rd_seen = 1'b1;
      rd_last = dma_addr;
    end
    if (oam_we) begin
      we_cnt++;
      if (!oa_seen) oa_first = oam_addr;
      oa_seen = 1'b1;
      oa_last = oam_addr;
    end
    if (dma_done) done_cnt++;
    last_rd   = dma_rd;
    last_addr = dma_addr;
    model_update(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset mid-cycle, optionally holding a write to the DMA register.
  task automatic do_reset(bit hold_we, bit chk);
    @(negedge clk);
    #2;
    reset     = 1'b1;
    cpu_addr  = REG_ADDR;
    cpu_we    = hold_we;
    cpu_wdata = 8'h09;
    #1;
    if (chk) check("reset_outputs", outs_now(), 36'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset   = 1'b0;
    m_busy  = 1'b0;
    m_prev  = 1'b0;
    m_armed = 1'b0;
    last_rd = 1'b0;
    cyc     = 0;
    #1;
    check("post_reset", outs_now(), model_out(cyc));
    model_update(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  initial begin
    vecs[0] = '{16'h4014, 1'b1, 8'h02, 8'h00, 1'b1, 1, 1'b0, 514, 256, 1, 16'h0200, 16'h02FF, 8'h00, 8'hFF};
    vecs[1] = '{16'h4014, 1'b1, 8'h02, 8'h00, 1'b0, 1, 1'b0, 513, 256, 1, 16'h0200, 16'h02FF, 8'h00, 8'hFF};
    vecs[2] = '{16'h4014, 1'b1, 8'h07, 8'hF0, 1'b1, 1, 1'b0, 514, 256, 1, 16'h0700, 16'h07FF, 8'hF0, 8'hEF};
    vecs[3] = '{16'h4015, 1'b1, 8'h02, 8'h00, 1'b0, 1, 1'b0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00};
    vecs[4] = '{16'h4014, 1'b0, 8'h02, 8'h00, 1'b0, 1, 1'b0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00};
    vecs[5] = '{16'h4014, 1'b1, 8'h02, 8'h00, 1'b0, 3, 1'b1, 513, 256, 1, 16'h0200, 16'h02FF, 8'h00, 8'hFF};

    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'(a);
    end

    #1 reset = 1'b1;
    do_reset(1'b0, 1'b1);
    idle_inputs();

    // Directed scenario table.
    for (int v = 0; v < 6; v++) begin
      for (int w = 0; w < 4 && ((cyc % 2 == 1) != vecs[v].align); w++) step();
      clear_stats();
      cpu_addr  = vecs[v].addr;
      cpu_we    = vecs[v].we;
      cpu_wdata = vecs[v].page;
      oam_base  = vecs[v].base;
      for (int k = 0; k < 530; k++) begin
        if (k == vecs[v].hold) cpu_we = 1'b0;
        if (vecs[v].second && k == 60) begin
          cpu_addr  = REG_ADDR;
          cpu_we    = 1'b1;
          cpu_wdata = 8'h05;
        end
        if (vecs[v].second && k == 61) cpu_we = 1'b0;
        step();
      end
      idle_inputs();
      check($sformatf("v%0d_active_cycles", v), 36'(act_cnt), 36'(vecs[v].exp_act));
      check($sformatf("v%0d_oam_we_count", v), 36'(we_cnt), 36'(vecs[v].exp_we));
      check($sformatf("v%0d_done_count", v), 36'(done_cnt), 36'(vecs[v].exp_done));
      check($sformatf("v%0d_rd_first", v), 36'(rd_first), 36'(vecs[v].exp_rd_first));
      check($sformatf("v%0d_rd_last", v), 36'(rd_last), 36'(vecs[v].exp_rd_last));
      check($sformatf("v%0d_oa_first", v), 36'(oa_first), 36'(vecs[v].exp_oa_first));
      check($sformatf("v%0d_oa_last", v), 36'(oa_last), 36'(vecs[v].exp_oa_last));
    end

    // Reset in the middle of a transfer, at the read of byte 100.
    step();
    clear_stats();
    cpu_addr = REG_ADDR; cpu_we = 1'b1; cpu_wdata = 8'h02; oam_base = 8'h00;
    step();
    idle_inputs();
    for (int k = 0; k < 600 && (cyc - m_halt - 1 - m_align) != 200; k++) step();
    check("reached_idx100", 36'(dma_addr), 36'(16'h0264));
    do_reset(1'b0, 1'b1);
    idle_inputs();
    clear_stats();
    for (int k = 0; k < 30; k++) step();
    check("abort_no_done", 36'(done_cnt), 36'd0);
    check("abort_no_we", 36'(we_cnt), 36'd0);

    // Fresh transfer from page 3 after the abort.
    clear_stats();
    cpu_addr = REG_ADDR; cpu_we = 1'b1; cpu_wdata = 8'h03;
    step();
    idle_inputs();
    for (int k = 0; k < 530; k++) step();
    check("p3_rd_first", 36'(rd_first), 36'(16'h0300));
    check("p3_rd_last", 36'(rd_last), 36'(16'h03FF));
    check("p3_we_count", 36'(we_cnt), 36'd256);
    check("p3_done_count", 36'(done_cnt), 36'd1);

    // Write strobe held high across reset must not trigger afterwards.
    do_reset(1'b1, 1'b0);
    clear_stats();
    cpu_addr = REG_ADDR; cpu_we = 1'b1; cpu_wdata = 8'h04;
    step();
    step();
    idle_inputs();
    for (int k = 0; k < 10; k++) step();
    check("held_we_no_trigger", 36'(act_cnt), 36'd0);

    // Randomized transfers with live OAMADDR and stray CPU writes.
    for (int t = 0; t < 5; t++) begin
      logic [7:0] pg;
      int wait_n;
      pg = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
      wait_n = int'($urandom_range(0, 3));
      for (int w = 0; w < wait_n + 1; w++) step();
      clear_stats();
      for (int k = 0; k < 530; k++) begin
        oam_base = 8'($urandom);
        if (k == 0) begin
          cpu_addr = REG_ADDR; cpu_we = 1'b1; cpu_wdata = pg;
        end else if (k < 500) begin
          cpu_addr  = ($urandom_range(0, 1) == 0) ? REG_ADDR : 16'h4015;
          cpu_we    = ($urandom_range(0, 3) == 0);
          cpu_wdata = 8'($urandom);
        end else begin
          idle_inputs();
        end
        step();
      end
      check($sformatf("rnd%0d_we_count", t), 36'(we_cnt), 36'd256);
      check($sformatf("rnd%0d_done_count", t), 36'(done_cnt), 36'd1);
      check($sformatf("rnd%0d_rd_first", t), 36'(rd_first), 36'({pg, 8'h00}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_engine.md
OAM_DMA_ENGINE -- requirements
Module: oam_dma_engine

Interface
REQ-001 SHALL have parameter DMA_REG, default 16'h4014, CPU address that triggers DMA.
REQ-002 SHALL have parameter XFER_LEN, default 256, bytes per transfer.
REQ-003 SHALL have clk: input, 1, system clock, one CPU cycle per clk.
REQ-004 SHALL have reset: input, 1, asynchronous, active-high.
REQ-005 SHALL have cpu_addr: input, 16, CPU address bus.
REQ-006 SHALL have cpu_we: input, 1, CPU write strobe.
REQ-007 SHALL have cpu_wdata: input, 8, CPU write data (page number).
REQ-008 SHALL have oam_base: input, 8, current PPU OAMADDR.
REQ-009 SHALL have ram_rdata: input, 8, source read data, valid the cycle after dma_rd.
REQ-010 SHALL have dma_active: output, 1, high while DMA owns the bus; stalls the CPU.
REQ-011 SHALL have dma_addr: output, 16, source address.
REQ-012 SHALL have dma_rd: output, 1, source read strobe.
REQ-013 SHALL have oam_addr: output, 8, OAM write address.
REQ-014 SHALL have oam_wdata: output, 8, OAM write data.
REQ-015 SHALL have oam_we: output, 1, OAM write strobe.
REQ-016 SHALL have dma_done: output, 1, one-cycle completion pulse.

Function
REQ-017 SHALL trigger only on a cpu_we rising edge (previous-cycle cpu_we low) with cpu_addr==DMA_REG while in IDLE; a held cpu_we SHALL NOT retrigger.
REQ-018 SHALL latch page = cpu_wdata on the trigger cycle; idx SHALL clear to 0.
REQ-019 SHALL keep a free-running parity flop cyc_odd: reset 0, toggles every clk.
REQ-020 SHALL use states IDLE, HALT, ALIGN, READ, WRITE, DONE.
REQ-021 SHALL transition IDLE->HALT on trigger; HALT is exactly 1 cycle.
REQ-022 SHALL transition HALT->READ if cyc_odd==1 in HALT, else HALT->ALIGN->READ; every READ cycle therefore has cyc_odd==0.
REQ-023 In READ: dma_rd=1, dma_addr={page, idx[7:0]}; next state WRITE.
REQ-024 In WRITE: oam_we=1, oam_wdata=ram_rdata, oam_addr=(oam_base+idx) mod 256.
REQ-025 WRITE with idx==XFER_LEN-1 SHALL go to DONE; otherwise idx increments and returns to READ.
REQ-026 DONE is 1 cycle with dma_done=1, then IDLE.
REQ-027 dma_active SHALL be 1 in HALT, ALIGN, READ and WRITE, and 0 in IDLE and DONE; busy length SHALL be 513 cycles (no ALIGN) or 514 cycles (with ALIGN).
REQ-028 Outside their states, dma_rd, oam_we and dma_done SHALL be 0; dma_addr, oam_addr and oam_wdata SHALL be 0.
REQ-029 Writes to DMA_REG while not IDLE SHALL be ignored, and page SHALL be unchanged.
REQ-030 idx SHALL be 9 bits so the final compare is exact; oam_addr SHALL wrap 8'hFF->8'h00 modulo 256.
REQ-031 oam_base SHALL be sampled every WRITE cycle; the block SHALL NOT store it.

Reset
REQ-032 On reset assertion, state=IDLE, idx=0, page=0, cyc_odd=0, prev_we=0, and all outputs=0, immediately (asynchronous).
REQ-033 Reset mid-transfer SHALL abort with no further oam_we and no dma_done pulse.
REQ-034 After reset release, the first trigger SHALL need a fresh cpu_we rising edge.

Structure
REQ-035 Shared package nes_mem_pkg SHALL hold the state enum dma_state_t, constant OAM_DMA_REG=16'h4014 and constant OAM_SIZE=256.
REQ-036 The write-edge detector SHALL be sub-module wr_edge_det (inputs clk, reset, we; output rise).
REQ-037 All state SHALL live in the clk domain; no latches.

Verification
REQ-038 Scenario: write 8'h02 to 4014 with cyc_odd=0 at HALT -> ALIGN present, 514 active cycles, dma_addr 16'h0200..16'h02FF, 256 oam_we pulses.
REQ-039 Scenario: same trigger with cyc_odd=1 at HALT -> no ALIGN, 513 active cycles, dma_done exactly once.
REQ-040 Scenario: oam_base=8'hF0, source bytes = address low byte -> oam_addr F0..FF then 00..EF, oam_wdata 00..FF in order.
REQ-041 Scenario: cpu_we held high at 4014 for 3 cycles, and a second write of 8'h05 during transfer -> one transfer only, page stays 8'h02.
REQ-042 Scenario: reset asserted at idx=100 -> outputs 0 same cycle, no dma_done; a later write of 8'h03 -> full transfer from 16'h0300.
REQ-043 Scenario: write to 16'h4015 or read of 16'h4014 -> no dma_active.
